// File: rtl/pt_pkg.sv
// ---------------------------------------------------------------------------
// pt_pkg
// Shared definitions for the PT2262-style waveform decoder (and the matching
// encoder): pulse timing limits expressed in oscillator periods (alpha),
// frame length, FSM state encoding and a small saturating-counter helper.
// ---------------------------------------------------------------------------
package pt_pkg;

  // Payload pulses per frame (12 tri-state symbols = 24 binary pulses)
  localparam int FRAME_BITS = 24;

  // Pulse timing limits in alpha
  localparam int HI_MIN_A    = 2;   // shorter high is a glitch
  localparam int LONG_MIN_A  = 8;   // high at or above this is a long (bit 1)
  localparam int PULSE_MAX_A = 16;  // longest legal high
  localparam int LO_MIN_A    = 2;   // shortest legal low between pulses
  localparam int LO_MAX_A    = 16;  // longest legal low between pulses
  localparam int SYNC_MIN_A  = 64;  // low at or above this is a sync gap

  // Decoder FSM states
  typedef enum logic [2:0] {
    ST_HUNT  = 3'd0,
    ST_ARMED = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_TAIL  = 3'd4
  } pt_state_e;

  // Increment v, holding at lim once reached
  function automatic logic [2:0] sat_inc3(input logic [2:0] v, input logic [2:0] lim);
    logic [2:0] r;
    if (v >= lim) begin
      r = lim;
    end else begin
      r = v + 3'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pt_dec_if.sv
// ---------------------------------------------------------------------------
// pt_dec_if
// Serial PT waveform plus the decoded payload side.
//   in    : raw serial PT waveform
//   data  : last accepted 24-bit payload
//   valid : one-cycle strobe when data updates
//   error : one-cycle strobe on a malformed pulse
//   busy  : high while a frame is being decoded
// master = waveform source / payload consumer, slave = decoder.
// ---------------------------------------------------------------------------
interface pt_dec_if;
  logic        in;
  logic [23:0] data;
  logic        valid;
  logic        error;
  logic        busy;

  modport master (output in, input data, input valid, input error, input busy);
  modport slave  (input in, output data, output valid, output error, output busy);
endinterface

// File: rtl/pt_pulse_meas.sv
// ---------------------------------------------------------------------------
// pt_pulse_meas
// Synchronizes the raw PT line, detects edges and measures how long each
// level is held.
//   clk, reset_n : clock, async active-low reset
//   in           : raw asynchronous line
//   level        : synchronized level that run refers to
//   run          : cycles the current level has been held (saturating)
//   dur          : length of the level that just ended (valid with rise/fall)
//   rise, fall   : one-cycle edge strobes
// ---------------------------------------------------------------------------
module pt_pulse_meas #(
  parameter int SAT_CLKS = 256,
  parameter int CNT_W    = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in,
  output logic             level,
  output logic [CNT_W-1:0] run,
  output logic [CNT_W-1:0] dur,
  output logic             rise,
  output logic             fall
);

  localparam logic [CNT_W-1:0] SAT_C = CNT_W'(SAT_CLKS);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             rise_r;
  logic             fall_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] dur_r;

  // Synchronizer, edge detect and saturating level-duration counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      cnt_r   <= '0;
      dur_r   <= '0;
    end else begin
      sync1_r <= in;
      sync2_r <= sync1_r;
      level_r <= sync2_r;
      rise_r  <= sync2_r & ~level_r;
      fall_r  <= ~sync2_r & level_r;
      // On an edge the finished level length is latched and counting restarts
      if (sync2_r != level_r) begin
        dur_r <= cnt_r;
        cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (cnt_r != SAT_C) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign level = level_r;
  assign run   = cnt_r;
  assign dur   = dur_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/pt_dec.sv
// ---------------------------------------------------------------------------
// pt_dec
// PT2262-style waveform decoder. Classifies each high/low on the synchronized
// line, shifts 24 payload pulses (MSB first), checks the closing sync, and
// publishes the payload once REPEATS identical consecutive frames are seen.
//   clk     : fabric clock
//   reset_n : asynchronous active-low reset
//   bus     : pt_dec_if slave (in, data, valid, error, busy)
// ---------------------------------------------------------------------------
module pt_dec
  import pt_pkg::*;
#(
  parameter int CLKS_PER_ALPHA = 4,
  parameter int REPEATS        = 2,
  parameter int SYNC_MIN_ALPHA = SYNC_MIN_A
) (
  input  logic     clk,
  input  logic     reset_n,
  pt_dec_if.slave  bus
);

  localparam int SAT_CLKS = SYNC_MIN_ALPHA * CLKS_PER_ALPHA;
  localparam int CNT_W    = $clog2(SAT_CLKS + 1);

  localparam logic [CNT_W-1:0] HI_MIN_C    = CNT_W'(HI_MIN_A * CLKS_PER_ALPHA);
  localparam logic [CNT_W-1:0] LONG_MIN_C  = CNT_W'(LONG_MIN_A * CLKS_PER_ALPHA);
  localparam logic [CNT_W-1:0] PULSE_MAX_C = CNT_W'(PULSE_MAX_A * CLKS_PER_ALPHA);
  localparam logic [CNT_W-1:0] LO_MIN_C    = CNT_W'(LO_MIN_A * CLKS_PER_ALPHA);
  localparam logic [CNT_W-1:0] LO_MAX_C    = CNT_W'(LO_MAX_A * CLKS_PER_ALPHA);
  localparam logic [CNT_W-1:0] SYNC_C      = CNT_W'(SAT_CLKS);
  localparam logic [4:0]       LAST_BIT_C  = 5'(FRAME_BITS);
  localparam logic [2:0]       REP_C       = 3'(REPEATS);

  logic             level_s;
  logic             rise_s;
  logic             fall_s;
  logic [CNT_W-1:0] run_s;
  logic [CNT_W-1:0] dur_s;

  pt_state_e   state_r;
  pt_state_e   next_s;
  logic        start_s;
  logic        shift_s;
  logic        err_s;
  logic        done_s;
  logic        bit_s;
  logic        same_s;
  logic [2:0]  match_nxt_s;
  logic        strobe_s;

  logic [4:0]  bitcnt_r;
  logic [23:0] shreg_r;
  logic [23:0] cand_r;
  logic        cand_vld_r;
  logic [2:0]  match_r;
  logic [23:0] data_r;
  logic        valid_r;
  logic        error_r;
  logic        busy_r;

  pt_pulse_meas #(
    .SAT_CLKS (SAT_CLKS),
    .CNT_W    (CNT_W)
  ) u_meas (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (bus.in),
    .level   (level_s),
    .run     (run_s),
    .dur     (dur_s),
    .rise    (rise_s),
    .fall    (fall_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_HUNT;
    end else begin
      state_r <= next_s;
    end
  end

  // FSM next-state logic; every return to HUNT from another state is an error
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_HUNT: begin
        if (!level_s && (run_s >= SYNC_C)) begin
          next_s = ST_ARMED;
        end else begin
          next_s = ST_HUNT;
        end
      end
      ST_ARMED: begin
        if (rise_s) begin
          next_s = ST_HIGH;
        end else begin
          next_s = ST_ARMED;
        end
      end
      ST_HIGH: begin
        if (fall_s) begin
          if ((dur_s < HI_MIN_C) || (dur_s > PULSE_MAX_C)) begin
            next_s = ST_HUNT;
          end else begin
            next_s = ST_LOW;
          end
        end else if (run_s > PULSE_MAX_C) begin
          // Line stuck high: give up without waiting for the falling edge
          next_s = ST_HUNT;
        end else begin
          next_s = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (rise_s) begin
          if ((dur_s < LO_MIN_C) || (dur_s > LO_MAX_C)) begin
            next_s = ST_HUNT;
          end else if (bitcnt_r == LAST_BIT_C) begin
            next_s = ST_TAIL;
          end else begin
            next_s = ST_HIGH;
          end
        end else if (run_s > LO_MAX_C) begin
          next_s = ST_HUNT;
        end else begin
          next_s = ST_LOW;
        end
      end
      ST_TAIL: begin
        // Sync pulse: one short high, then nothing until the gap is long enough
        if (rise_s) begin
          next_s = ST_HUNT;
        end else if (fall_s && (dur_s < HI_MIN_C)) begin
          next_s = ST_HUNT;
        end else if (level_s && (run_s >= LONG_MIN_C)) begin
          next_s = ST_HUNT;
        end else if (!level_s && (run_s >= SYNC_C)) begin
          next_s = ST_ARMED;
        end else begin
          next_s = ST_TAIL;
        end
      end
      default: begin
        next_s = ST_HUNT;
      end
    endcase
  end

  // FSM outputs and repeat-match decision
  always_comb begin
    start_s     = (state_r == ST_ARMED) && (next_s == ST_HIGH);
    shift_s     = (state_r == ST_HIGH) && (next_s == ST_LOW);
    err_s       = (state_r != ST_HUNT) && (next_s == ST_HUNT);
    done_s      = (state_r == ST_TAIL) && (next_s == ST_ARMED);
    bit_s       = (dur_s >= LONG_MIN_C);
    same_s      = cand_vld_r && (shreg_r == cand_r);
    match_nxt_s = same_s ? sat_inc3(match_r, REP_C) : 3'd1;
    // Strobe only on the frame that first brings the count to REPEATS
    strobe_s    = done_s && (match_nxt_s == REP_C) && !(same_s && (match_r == REP_C));
  end

  // Payload shift register, repeat tracking and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt_r   <= 5'd0;
      shreg_r    <= 24'd0;
      cand_r     <= 24'd0;
      cand_vld_r <= 1'b0;
      match_r    <= 3'd0;
      data_r     <= 24'd0;
      valid_r    <= 1'b0;
      error_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      valid_r <= strobe_s;
      error_r <= err_s;
      busy_r  <= (next_s == ST_HIGH) || (next_s == ST_LOW) || (next_s == ST_TAIL);

      if (start_s) begin
        bitcnt_r <= 5'd0;
      end else if (shift_s) begin
        bitcnt_r <= bitcnt_r + 5'd1;
        shreg_r  <= {shreg_r[FRAME_BITS-2:0], bit_s};
      end else begin
        bitcnt_r <= bitcnt_r;
      end

      if (err_s) begin
        match_r    <= 3'd0;
        cand_vld_r <= 1'b0;
      end else if (done_s) begin
        match_r    <= match_nxt_s;
        cand_r     <= shreg_r;
        cand_vld_r <= 1'b1;
        if (strobe_s) begin
          data_r <= shreg_r;
        end else begin
          data_r <= data_r;
        end
      end else begin
        match_r <= match_r;
      end
    end
  end

  assign bus.data  = data_r;
  assign bus.valid = valid_r;
  assign bus.error = error_r;
  assign bus.busy  = busy_r;

endmodule
